// File: rtl/challenge_scheduler.sv
// challenge_scheduler: round-robin arbiter sharing one 16-bit challenge LFSR among requesters
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   req          level request per requester
//   lfsr_random  current LFSR state
//   lfsr_enable  LFSR shift strobe, high for every STEP cycle
//   chal_valid   challenge offered to the current owner
//   chal_grant   one-hot owner of the offered challenge, zero when idle
//   chal_data    challenge word latched after the final shift
//   chal_ready   owner accepts; handshake is chal_valid && chal_ready
//   busy         scheduler is not idle
//
// Optional feature: define CHALLENGE_REPEAT_CHECK_EN to re-step the LFSR whenever the
// freshly latched word equals the last word that was actually handed out.
module challenge_scheduler #(
    parameter int N_REQ = 4,
    parameter int STEPS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [15:0]      lfsr_random,
    output logic             lfsr_enable,
    output logic             chal_valid,
    output logic [N_REQ-1:0] chal_grant,
    output logic [15:0]      chal_data,
    input  logic             chal_ready,
    output logic             busy
);
    localparam int PW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, STEP, LATCH, OFFER} state_t;

    state_t           state;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    win;
    logic [PW-1:0]    pick;
    logic [N_REQ-1:0] grant;
    logic [7:0]       step_cnt;
    int               idx;
`ifdef CHALLENGE_REPEAT_CHECK_EN
    logic [15:0]      last_issued;
`endif

    // Scan downward so the lowest offset from rr_ptr is the one left standing.
    always_comb begin
        pick = '0;
        idx  = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (req[idx[PW-1:0]]) pick = idx[PW-1:0];
        end
    end

    // The LFSR sees one shift per STEP cycle, so the strobe is decoded straight from state.
    assign lfsr_enable = state == STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            win         <= '0;
            grant       <= '0;
            step_cnt    <= '0;
            chal_valid  <= 1'b0;
            chal_grant  <= '0;
            chal_data   <= '0;
            busy        <= 1'b0;
`ifdef CHALLENGE_REPEAT_CHECK_EN
            last_issued <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        win      <= pick;
                        grant    <= N_REQ'(1) << pick;
                        step_cnt <= 8'(STEPS);
                        busy     <= 1'b1;
                        state    <= STEP;
                    end
                end
                STEP: begin
                    step_cnt <= step_cnt - 8'd1;
                    if (step_cnt == 8'd1) state <= LATCH;
                end
                LATCH: begin
`ifdef CHALLENGE_REPEAT_CHECK_EN
                    if (lfsr_random == last_issued) begin
                        step_cnt <= 8'd1;
                        state    <= STEP;
                    end else begin
                        chal_data  <= lfsr_random;
                        chal_valid <= 1'b1;
                        chal_grant <= grant;
                        state      <= OFFER;
                    end
`else
                    chal_data  <= lfsr_random;
                    chal_valid <= 1'b1;
                    chal_grant <= grant;
                    state      <= OFFER;
`endif
                end
                OFFER: begin
                    // Handshake and abort both release the slot; only a handshake records the word.
                    if (chal_ready || !(|(req & grant))) begin
                        chal_valid <= 1'b0;
                        chal_grant <= '0;
                        busy       <= 1'b0;
                        rr_ptr     <= (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
                        state      <= IDLE;
`ifdef CHALLENGE_REPEAT_CHECK_EN
                        if (chal_ready) last_issued <= chal_data;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_challenge_scheduler.sv
// tb_challenge_scheduler: self-checking bench for challenge_scheduler with a timeline model
module tb_challenge_scheduler;
    localparam int N  = 4;
    localparam int ST = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          chal_ready = 1'b1;
    logic          force_once = 1'b0;
    logic [N-1:0]  req = '0;
    logic [15:0]   lfsr = 16'hACE1;
    logic [15:0]   lfsr_random;
    logic          lfsr_enable;
    logic          chal_valid;
    logic [N-1:0]  chal_grant;
    logic [15:0]   chal_data;
    logic          busy;

    int checks = 0;
    int errors = 0;

    bit          chk_on  = 0;
    bit          m_act   = 0;
    int          m_t     = 0;
    int          m_latch = ST + 1;
    int          m_owner = 0;
    int          m_ptr   = 0;
    logic [15:0] m_data  = '0;
    logic [15:0] m_last  = '0;

    challenge_scheduler #(.N_REQ(N), .STEPS(ST)) dut (
        .clk(clk), .rst(rst), .req(req), .lfsr_random(lfsr_random),
        .lfsr_enable(lfsr_enable), .chal_valid(chal_valid), .chal_grant(chal_grant),
        .chal_data(chal_data), .chal_ready(chal_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic [15:0] lfsr_n(input logic [15:0] s, input int n);
        logic [15:0] v = s;
        for (int i = 0; i < n; i++) v = lfsr_next(v);
        return v;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    // The first LATCH of a challenge can be made to see the previously issued word.
    assign lfsr_random = (force_once && m_act && m_t == ST + 1) ? m_last : lfsr;

    always @(posedge clk) begin
        if (rst) lfsr <= 16'hACE1;
        else if (lfsr_enable) lfsr <= lfsr_next(lfsr);
    end

    // Timeline model: m_t counts cycles since the grant decision, m_latch is the cycle the word is taken.
    always @(posedge clk) begin
        if (rst) begin
            m_act  <= 0;
            m_t    <= 0;
            m_ptr  <= 0;
            m_data <= '0;
            m_last <= '0;
        end else if (!m_act) begin
            if (|req) begin
                m_owner <= rr_pick(req, m_ptr);
                m_act   <= 1;
                m_t     <= 1;
                m_latch <= ST + 1;
            end
        end else if (m_t < m_latch) begin
            m_t <= m_t + 1;
        end else if (m_t == m_latch) begin
`ifdef CHALLENGE_REPEAT_CHECK_EN
            if (lfsr_random == m_last) m_latch <= m_latch + 2;
            else m_data <= lfsr_random;
`else
            m_data <= lfsr_random;
`endif
            m_t <= m_t + 1;
        end else if (chal_ready || !req[m_owner]) begin
            m_act <= 0;
            m_ptr <= (m_owner + 1) % N;
            if (chal_ready) m_last <= m_data;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            bit ev;
            ev = m_act && m_t > m_latch;
            check("m_enable", 32'(lfsr_enable),
                  32'(m_act && m_t >= 1 && m_t < m_latch && (m_t <= ST || (m_t - ST) % 2 == 0)));
            check("m_valid", 32'(chal_valid), 32'(ev));
            check("m_grant", 32'(chal_grant), ev ? (32'd1 << m_owner) : 32'd0);
            check("m_data", 32'(chal_data), 32'(m_data));
            check("m_busy", 32'(busy), 32'(m_act));
        end
    end

    task automatic run(output int cyc, output int ens);
        cyc = -1;
        ens = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (lfsr_enable) ens++;
            if (chal_valid) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_enable"}, 32'(lfsr_enable), 0);
        check({nm, "_valid"}, 32'(chal_valid), 0);
        check({nm, "_grant"}, 32'(chal_grant), 0);
        check({nm, "_data"}, 32'(chal_data), 0);
        check({nm, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int          cyc;
        int          ens;
        logic [15:0] d;
        logic [N-1:0] g;
        logic [3:0]  order [5];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        repeat (3) @(negedge clk);
        chk_on = 1;
        check_reset_outputs("reset");
        rst = 0;

        req = 4'b0001;
        run(cyc, ens);
        check("single_cycle", cyc, 18);
        check("single_enables", ens, 16);
        check("single_grant", 32'(chal_grant), 4'b0001);
        check("single_data", 32'(chal_data), 32'(lfsr_n(16'hACE1, 16)));
        req = 0;
        @(negedge clk);

        rst = 1;
        @(negedge clk);
        rst = 0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            run(cyc, ens);
            check("rr_grant", 32'(chal_grant), 32'(order[k]));
            check("rr_period", cyc, k == 0 ? 18 : 19);
            check("rr_enables", ens, 16);
        end
        req = 0;
        @(negedge clk);

        chal_ready = 0;
        req = 4'b0001;
        run(cyc, ens);
        check("bp_cycle", cyc, 18);
        d = chal_data;
        g = chal_grant;
        check("bp_grant", 32'(g), 4'b0001);
        repeat (10) begin
            @(negedge clk);
            check("bp_valid", 32'(chal_valid), 1);
            check("bp_data_hold", 32'(chal_data), 32'(d));
            check("bp_grant_hold", 32'(chal_grant), 32'(g));
            check("bp_enable", 32'(lfsr_enable), 0);
        end
        chal_ready = 1;
        @(negedge clk);
        check("bp_done_valid", 32'(chal_valid), 0);
        check("bp_done_busy", 32'(busy), 0);
        req = 0;
        @(negedge clk);

        chal_ready = 0;
        req = 4'b0110;
        run(cyc, ens);
        check("ab_cycle", cyc, 18);
        check("ab_grant", 32'(chal_grant), 4'b0010);
        @(negedge clk);
        check("ab_valid2", 32'(chal_valid), 1);
        req = 4'b0101;
        @(negedge clk);
        check("ab_valid_low", 32'(chal_valid), 0);
        check("ab_grant_low", 32'(chal_grant), 0);
        chal_ready = 1;
        run(cyc, ens);
        check("ab_next_cycle", cyc, 18);
        check("ab_next_grant", 32'(chal_grant), 4'b0100);
        req = 0;
        @(negedge clk);

        req = 4'b0001;
        ens = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (lfsr_enable) ens++;
        end
        check("rs_pre_enables", ens, 5);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check_reset_outputs("rs");
        run(cyc, ens);
        check("rs_cycle", cyc, 18);
        check("rs_enables", ens, 16);
        check("rs_data", 32'(chal_data), 32'(lfsr_n(16'hACE1, 16)));
        d = chal_data;
        req = 0;
        @(negedge clk);

`ifdef CHALLENGE_REPEAT_CHECK_EN
        force_once = 1;
        req = 4'b0001;
        run(cyc, ens);
        check("rp_cycle", cyc, 20);
        check("rp_enables", ens, 17);
        check("rp_data_new", 32'(chal_data == d), 0);
        force_once = 0;
        req = 0;
        @(negedge clk);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
